// File: rtl/uart_apb_csr_if.sv
// APB slave bus bundle for the UART register block.
// The master drives the address/control phase; the slave returns read data.
interface uart_apb_csr_if;
    logic        pSel;
    logic        pEnable;
    logic        pWrite;
    logic [7:0]  pAddr;
    logic [31:0] pWdata;
    logic [31:0] pReadData;

    modport master (
        output pSel, pEnable, pWrite, pAddr, pWdata,
        input  pReadData
    );

    modport slave (
        input  pSel, pEnable, pWrite, pAddr, pWdata,
        output pReadData
    );
endinterface

// File: rtl/uart_apb_csr.sv
// UART APB register block with TX/RX byte FIFOs, baud divisor, frame config
// and a masked sticky W1C interrupt scheme driving one registered Irq line.
module uart_apb_csr #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BAUD_RST   = 16'd54
) (
    input  logic                 pClk,
    input  logic                 pReset,
    uart_apb_csr_if.slave        apb,
    output logic [7:0]           TxData,
    output logic                 TxValid,
    input  logic                 TxReady,
    input  logic [7:0]           RxData,
    input  logic                 RxValid,
    input  logic                 RxFrameErr,
    input  logic                 RxParityErr,
    output logic [15:0]          BaudDiv,
    output logic [1:0]           CfgDls,
    output logic                 CfgStop,
    output logic                 CfgPen,
    output logic                 CfgEps,
    output logic                 TxEnable,
    output logic                 RxEnable,
    output logic                 Irq
);
    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1'b1);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1'b1);

    localparam logic [7:0] ADDR_DATA  = 8'h00;
    localparam logic [7:0] ADDR_CTRL  = 8'h04;
    localparam logic [7:0] ADDR_BAUD  = 8'h08;
    localparam logic [7:0] ADDR_STAT  = 8'h0C;
    localparam logic [7:0] ADDR_INTEN = 8'h10;
    localparam logic [7:0] ADDR_INTST = 8'h14;
    localparam logic [7:0] ADDR_THR   = 8'h18;

    logic [6:0]    ctrl_r;
    logic [15:0]   baud_r;
    logic [5:0]    intEn_r;
    logic [3:0]    sticky_r;
    logic [7:0]    rxThr_r, txThr_r;
    logic          irq_r;

    logic [7:0]    txMem_r [FIFO_DEPTH];
    logic [7:0]    rxMem_r [FIFO_DEPTH];
    logic [AW-1:0] txWptr_r, txRptr_r, rxWptr_r, rxRptr_r;
    logic [AW:0]   txCount_r, rxCount_r;

    logic          wrEn_s, rdEn_s;
    logic          txEmpty_s, txFull_s, rxEmpty_s, rxFull_s;
    logic          txWrite_s, txPush_s, txPop_s, txFlush_s, txOvf_s;
    logic          rxReq_s, rxPush_s, rxPop_s, rxFlush_s, rxOvr_s;
    logic [7:0]    txLevel_s, rxLevel_s;
    logic [3:0]    stickySet_s, stickyClr_s;
    logic [5:0]    intStat_s;
    logic [31:0]   readData_s;
    logic          unusedBits_s;

    assign wrEn_s    = apb.pSel & apb.pEnable & apb.pWrite;
    assign rdEn_s    = apb.pSel & apb.pEnable & ~apb.pWrite;

    assign txEmpty_s = (txCount_r == '0);
    assign txFull_s  = (txCount_r == DEPTH_C);
    assign rxEmpty_s = (rxCount_r == '0);
    assign rxFull_s  = (rxCount_r == DEPTH_C);
    assign txLevel_s = 8'(txCount_r);
    assign rxLevel_s = 8'(rxCount_r);

    // A full FIFO still accepts a push when the opposite side pops in the same cycle.
    assign txFlush_s = wrEn_s & (apb.pAddr == ADDR_CTRL) & apb.pWdata[8];
    assign txPop_s   = TxValid & TxReady;
    assign txWrite_s = wrEn_s & (apb.pAddr == ADDR_DATA);
    assign txPush_s  = txWrite_s & (~txFull_s | txPop_s) & ~txFlush_s;
    assign txOvf_s   = txWrite_s & txFull_s & ~txPop_s;

    assign rxFlush_s = wrEn_s & (apb.pAddr == ADDR_CTRL) & apb.pWdata[9];
    assign rxPop_s   = rdEn_s & (apb.pAddr == ADDR_DATA) & ~rxEmpty_s;
    assign rxReq_s   = RxValid & ctrl_r[1];
    assign rxPush_s  = rxReq_s & (~rxFull_s | rxPop_s) & ~rxFlush_s;
    assign rxOvr_s   = rxReq_s & rxFull_s & ~rxPop_s;

    assign stickySet_s = {txOvf_s, rxReq_s & RxParityErr, rxReq_s & RxFrameErr, rxOvr_s};
    assign stickyClr_s = (wrEn_s & (apb.pAddr == ADDR_INTST)) ? apb.pWdata[5:2] : 4'd0;
    assign intStat_s   = {sticky_r, (txLevel_s <= txThr_r), (rxLevel_s >= rxThr_r)};

    assign TxData    = txMem_r[txRptr_r];
    assign TxValid   = ctrl_r[0] & ~txEmpty_s;
    assign TxEnable  = ctrl_r[0];
    assign RxEnable  = ctrl_r[1];
    assign CfgDls    = ctrl_r[3:2];
    assign CfgStop   = ctrl_r[4];
    assign CfgPen    = ctrl_r[5];
    assign CfgEps    = ctrl_r[6];
    assign BaudDiv   = baud_r;
    assign Irq       = irq_r;
    assign apb.pReadData = readData_s;
    assign unusedBits_s  = &{1'b0, apb.pWdata[31:16]};

    // Configuration registers written from the APB access phase.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            ctrl_r  <= 7'd0;
            baud_r  <= BAUD_RST;
            intEn_r <= 6'd0;
            rxThr_r <= 8'd1;
            txThr_r <= 8'd0;
        end else if (wrEn_s) begin
            case (apb.pAddr)
                ADDR_CTRL:  ctrl_r  <= apb.pWdata[6:0];
                ADDR_BAUD:  baud_r  <= apb.pWdata[15:0];
                ADDR_INTEN: intEn_r <= apb.pWdata[5:0];
                ADDR_THR: begin
                    rxThr_r <= apb.pWdata[7:0];
                    txThr_r <= apb.pWdata[15:8];
                end
                default:    ctrl_r  <= ctrl_r;
            endcase
        end
    end

    // Sticky flags: a set event outranks a same-cycle W1C; Irq lags by one edge.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            sticky_r <= 4'd0;
            irq_r    <= 1'b0;
        end else begin
            sticky_r <= (sticky_r & ~stickyClr_s) | stickySet_s;
            irq_r    <= |(intStat_s & intEn_r);
        end
    end

    // TX FIFO pointers and level; flush outranks push and pop.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            txWptr_r  <= '0;
            txRptr_r  <= '0;
            txCount_r <= '0;
        end else if (txFlush_s) begin
            txWptr_r  <= '0;
            txRptr_r  <= '0;
            txCount_r <= '0;
        end else begin
            if (txPush_s) txWptr_r <= txWptr_r + PTR_ONE;
            if (txPop_s)  txRptr_r <= txRptr_r + PTR_ONE;
            case ({txPush_s, txPop_s})
                2'b10:   txCount_r <= txCount_r + CNT_ONE;
                2'b01:   txCount_r <= txCount_r - CNT_ONE;
                default: txCount_r <= txCount_r;
            endcase
        end
    end

    // RX FIFO pointers and level; flush outranks push and pop.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            rxWptr_r  <= '0;
            rxRptr_r  <= '0;
            rxCount_r <= '0;
        end else if (rxFlush_s) begin
            rxWptr_r  <= '0;
            rxRptr_r  <= '0;
            rxCount_r <= '0;
        end else begin
            if (rxPush_s) rxWptr_r <= rxWptr_r + PTR_ONE;
            if (rxPop_s)  rxRptr_r <= rxRptr_r + PTR_ONE;
            case ({rxPush_s, rxPop_s})
                2'b10:   rxCount_r <= rxCount_r + CNT_ONE;
                2'b01:   rxCount_r <= rxCount_r - CNT_ONE;
                default: rxCount_r <= rxCount_r;
            endcase
        end
    end

    // FIFO storage; contents are only observable through the gated heads.
    always_ff @(posedge pClk) begin
        if (txPush_s) txMem_r[txWptr_r] <= apb.pWdata[7:0];
        if (rxPush_s) rxMem_r[rxWptr_r] <= RxData;
    end

    // Read data mux, zero outside a read access and for unmapped addresses.
    always_comb begin
        readData_s = 32'd0;
        if (rdEn_s) begin
            case (apb.pAddr)
                ADDR_DATA:  readData_s = rxEmpty_s ? 32'd0 : {24'd0, rxMem_r[rxRptr_r]};
                ADDR_CTRL:  readData_s = {25'd0, ctrl_r};
                ADDR_BAUD:  readData_s = {16'd0, baud_r};
                ADDR_STAT:  readData_s = {8'd0, rxLevel_s, txLevel_s, 4'd0,
                                          rxFull_s, rxEmpty_s, txFull_s, txEmpty_s};
                ADDR_INTEN: readData_s = {26'd0, intEn_r};
                ADDR_INTST: readData_s = {26'd0, intStat_s};
                ADDR_THR:   readData_s = {16'd0, txThr_r, rxThr_r};
                default:    readData_s = 32'd0;
            endcase
        end else begin
            readData_s = 32'd0;
        end
    end
endmodule

// File: tb/tb_uart_apb_csr.sv
// Directed bench for uart_apb_csr: a register vector table followed by
// hand-written FIFO, interrupt and flush sequences with hand-computed results.
module tb_uart_apb_csr;
    logic        pClk = 1'b0;
    logic        pReset = 1'b1;
    logic        TxReady = 1'b0;
    logic [7:0]  RxData = 8'd0;
    logic        RxValid = 1'b0;
    logic        RxFrameErr = 1'b0;
    logic        RxParityErr = 1'b0;
    logic [7:0]  TxData;
    logic        TxValid;
    logic [15:0] BaudDiv;
    logic [1:0]  CfgDls;
    logic        CfgStop, CfgPen, CfgEps, TxEnable, RxEnable, Irq;

    int errors = 0;
    int checks = 0;

    uart_apb_csr_if bus ();

    uart_apb_csr #(.FIFO_DEPTH(16), .BAUD_RST(16'd54)) dut (
        .pClk(pClk), .pReset(pReset), .apb(bus),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid),
        .RxFrameErr(RxFrameErr), .RxParityErr(RxParityErr),
        .BaudDiv(BaudDiv), .CfgDls(CfgDls), .CfgStop(CfgStop),
        .CfgPen(CfgPen), .CfgEps(CfgEps),
        .TxEnable(TxEnable), .RxEnable(RxEnable), .Irq(Irq)
    );

    always #5 pClk = ~pClk;

    localparam logic [7:0] A_DATA = 8'h00, A_CTRL = 8'h04, A_BAUD = 8'h08,
                           A_STAT = 8'h0C, A_INTEN = 8'h10, A_INTST = 8'h14,
                           A_THR = 8'h18;

    typedef struct {
        logic        isWrite;
        logic [7:0]  addr;
        logic [31:0] data;   // write data, or expected read data
        string       name;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // One APB transfer (setup + access); side inputs are held only during the access phase.
    task automatic apbAccess(input logic wr, input logic [7:0] a, input logic [31:0] d,
                             input logic rxV, input logic [7:0] rxD, input logic fe,
                             input logic pe, input logic txR, output logic [31:0] rd);
        bus.pSel = 1'b1; bus.pEnable = 1'b0; bus.pWrite = wr; bus.pAddr = a; bus.pWdata = d;
        @(posedge pClk); #1;
        bus.pEnable = 1'b1;
        RxValid = rxV; RxData = rxD; RxFrameErr = fe; RxParityErr = pe; TxReady = txR;
        #3 rd = bus.pReadData;
        @(posedge pClk); #1;
        bus.pSel = 1'b0; bus.pEnable = 1'b0; bus.pWrite = 1'b0;
        RxValid = 1'b0; RxFrameErr = 1'b0; RxParityErr = 1'b0; TxReady = 1'b0;
    endtask

    task automatic apbWr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apbAccess(1'b1, a, d, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, dummy);
    endtask

    task automatic apbRdChk(input logic [7:0] a, input logic [31:0] exp, input string name);
        logic [31:0] r;
        apbAccess(1'b0, a, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, r);
        check(name, r, exp);
    endtask

    task automatic rxPush(input logic [7:0] d, input logic fe, input logic pe);
        RxValid = 1'b1; RxData = d; RxFrameErr = fe; RxParityErr = pe;
        @(posedge pClk); #1;
        RxValid = 1'b0; RxFrameErr = 1'b0; RxParityErr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        vecs[0]  = '{1'b0, A_BAUD,  32'h0000_0036, "rst_baud"};
        vecs[1]  = '{1'b0, A_STAT,  32'h0000_0005, "rst_status"};
        vecs[2]  = '{1'b0, A_CTRL,  32'h0000_0000, "rst_ctrl"};
        vecs[3]  = '{1'b0, A_INTEN, 32'h0000_0000, "rst_inten"};
        vecs[4]  = '{1'b0, A_INTST, 32'h0000_0002, "rst_intstat"};
        vecs[5]  = '{1'b0, A_THR,   32'h0000_0001, "rst_thr"};
        vecs[6]  = '{1'b0, 8'h1C,   32'h0000_0000, "unmapped_1c"};
        vecs[7]  = '{1'b1, A_BAUD,  32'h0001_1234, "wr_baud"};
        vecs[8]  = '{1'b0, A_BAUD,  32'h0000_1234, "rd_baud"};
        vecs[9]  = '{1'b1, A_CTRL,  32'h0000_037F, "wr_ctrl"};
        vecs[10] = '{1'b0, A_CTRL,  32'h0000_007F, "rd_ctrl_pulses0"};
        vecs[11] = '{1'b1, A_INTEN, 32'hFFFF_FFFF, "wr_inten"};
        vecs[12] = '{1'b0, A_INTEN, 32'h0000_003F, "rd_inten"};
        vecs[13] = '{1'b1, A_THR,   32'h1234_0302, "wr_thr"};
        vecs[14] = '{1'b0, A_THR,   32'h0000_0302, "rd_thr"};
        vecs[15] = '{1'b1, 8'h40,   32'hFFFF_FFFF, "wr_unmapped"};
        vecs[16] = '{1'b0, 8'h40,   32'h0000_0000, "rd_unmapped"};
        vecs[17] = '{1'b1, A_INTEN, 32'h0000_0000, "restore_inten"};
        vecs[18] = '{1'b1, A_THR,   32'h0000_0001, "restore_thr"};

        bus.pSel = 1'b0; bus.pEnable = 1'b0; bus.pWrite = 1'b0;
        bus.pAddr = 8'd0; bus.pWdata = 32'd0;
        repeat (3) @(posedge pClk);
        #1 pReset = 1'b0;

        check("rst_irq", {31'd0, Irq}, 32'd0);
        check("rst_txvalid", {31'd0, TxValid}, 32'd0);
        check("rst_bauddiv", {16'd0, BaudDiv}, 32'd54);
        check("rst_cfg", {25'd0, CfgEps, CfgPen, CfgStop, CfgDls, RxEnable, TxEnable}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].isWrite) apbWr(vecs[i].addr, vecs[i].data);
            else apbRdChk(vecs[i].addr, vecs[i].data, vecs[i].name);
        end
        check("bauddiv_out", {16'd0, BaudDiv}, 32'h0000_1234);
        apbWr(A_CTRL, 32'h0000_0075);
        check("cfg_out", {25'd0, CfgEps, CfgPen, CfgStop, CfgDls, RxEnable, TxEnable}, 32'h75);

        // TX path: two bytes held, then drained by two TxReady cycles.
        apbWr(A_CTRL, 32'h0000_0001);
        apbWr(A_DATA, 32'h0000_00A5);
        apbWr(A_DATA, 32'h0000_003C);
        apbRdChk(A_STAT, 32'h0000_0204, "tx_level2");
        check("tx_head_a5", {24'd0, TxData}, 32'hA5);
        check("tx_valid1", {31'd0, TxValid}, 32'd1);
        TxReady = 1'b1;
        @(posedge pClk); #1;
        check("tx_head_3c", {24'd0, TxData}, 32'h3C);
        @(posedge pClk); #1;
        TxReady = 1'b0;
        check("tx_valid_drained", {31'd0, TxValid}, 32'd0);
        apbRdChk(A_STAT, 32'h0000_0005, "tx_empty_status");

        // TX overflow: 17 writes into 16 entries.
        for (int i = 0; i < 17; i++) apbWr(A_DATA, 32'h40 + i);
        apbRdChk(A_STAT, 32'h0000_1006, "tx_full_status");
        check("tx_full_head", {24'd0, TxData}, 32'h40);
        apbRdChk(A_INTST, 32'h0000_0020, "txovf_set");
        apbWr(A_INTST, 32'h0000_0020);
        apbRdChk(A_INTST, 32'h0000_0000, "txovf_w1c");
        apbWr(A_CTRL, 32'h0000_0101);
        apbRdChk(A_STAT, 32'h0000_0005, "tx_flushed");

        // RX threshold interrupt timing.
        apbWr(A_CTRL, 32'h0000_0003);
        apbWr(A_INTEN, 32'h0000_0001);
        apbWr(A_THR, 32'h0000_0002);
        rxPush(8'h11, 1'b0, 1'b0);
        rxPush(8'h22, 1'b0, 1'b0);
        check("irq_not_yet", {31'd0, Irq}, 32'd0);
        @(posedge pClk); #1;
        check("irq_rise", {31'd0, Irq}, 32'd1);
        apbRdChk(A_DATA, 32'h0000_0011, "rx_pop_11");
        apbRdChk(A_DATA, 32'h0000_0022, "rx_pop_22");
        check("irq_fall", {31'd0, Irq}, 32'd0);
        apbRdChk(A_DATA, 32'h0000_0000, "rx_empty_read");
        apbRdChk(A_STAT, 32'h0000_0005, "rx_empty_status");

        // Full RX FIFO: push accepted with a same-cycle DATA read.
        apbWr(A_INTEN, 32'h0000_0000);
        for (int i = 0; i < 16; i++) rxPush(8'h80 + 8'(i), 1'b0, 1'b0);
        apbRdChk(A_STAT, 32'h0010_0009, "rx_full_status");
        apbAccess(1'b0, A_DATA, 32'd0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, r);
        check("rx_full_pop_data", r, 32'h80);
        apbRdChk(A_STAT, 32'h0010_0009, "rx_level_held");
        apbRdChk(A_INTST, 32'h0000_000B, "fe_no_rxovr");
        for (int i = 0; i < 16; i++) begin
            apbAccess(1'b0, A_DATA, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, r);
            check($sformatf("rx_drain_%0d", i), r, (i < 15) ? 32'h81 + i : 32'hEE);
        end

        // RX overflow with parity error, then set-beats-W1C.
        apbWr(A_INTST, 32'h0000_003C);
        apbRdChk(A_INTST, 32'h0000_0002, "intst_cleared");
        for (int i = 0; i < 16; i++) rxPush(8'(i), 1'b0, 1'b0);
        rxPush(8'hFF, 1'b0, 1'b1);
        apbRdChk(A_STAT, 32'h0010_0009, "rx_ovr_level");
        apbRdChk(A_INTST, 32'h0000_0017, "rxovr_pe_set");
        apbAccess(1'b1, A_INTST, 32'h0000_0008, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, r);
        apbRdChk(A_INTST, 32'h0000_001F, "set_beats_w1c");
        apbWr(A_CTRL, 32'h0000_0203);
        apbRdChk(A_STAT, 32'h0000_0005, "rx_flushed");

        // RxValid ignored while RXEN is low.
        apbWr(A_CTRL, 32'h0000_0001);
        apbWr(A_INTST, 32'h0000_003C);
        rxPush(8'h55, 1'b1, 1'b1);
        apbRdChk(A_STAT, 32'h0000_0005, "rx_disabled_status");
        apbRdChk(A_INTST, 32'h0000_0002, "rx_disabled_flags");

        // TX flush concurrent with a TxReady pop.
        for (int i = 0; i < 3; i++) apbWr(A_DATA, 32'h10 + i);
        apbRdChk(A_STAT, 32'h0000_0304, "tx_level3");
        check("tx_head_10", {24'd0, TxData}, 32'h10);
        apbAccess(1'b1, A_CTRL, 32'h0000_0101, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, r);
        check("flush_txvalid", {31'd0, TxValid}, 32'd0);
        apbRdChk(A_STAT, 32'h0000_0005, "flush_status");
        apbRdChk(A_CTRL, 32'h0000_0001, "flush_ctrl_rb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_apb_csr.md
# uart_apb_csr

Parametrised APB register and buffering block for the UART, sitting between the APB bus and the UART transmitter/receiver cores. It holds configurable-depth TX and RX FIFOs and a 16-bit baud divisor. It also holds frame-format control, FIFO level reporting, programmable thresholds, and a masked, sticky, write-1-to-clear interrupt scheme driving a single interrupt line.

## Interface
- FIFO_DEPTH, 16, entries per FIFO; power of two, 2..128
- BAUD_RST, 16'd54, reset value of the baud divisor
- pClk  in  1  clock
- pReset  in  1  asynchronous, active-high reset
- pSel, pEnable, pWrite  in  1 each  APB control
- pAddr  in  8  byte address
- pWdata  in  32  write data
- pReadData  out  32  read data
- TxData  out  8  head of the TX FIFO
- TxValid  out  1  TX byte available to the transmitter
- TxReady  in  1  transmitter accepts the byte
- RxData  in  8  received byte
- RxValid  in  1  one-cycle pulse; RxData and the error flags are valid
- RxFrameErr, RxParityErr  in  1 each  error qualifiers for RxValid
- BaudDiv  out  16  baud divisor
- CfgDls  out  2  data length select
- CfgStop, CfgPen, CfgEps  out  1 each  stop bits, parity enable, even parity
- TxEnable, RxEnable  out  1 each  core enables
- Irq  out  1  interrupt request

## Operation
- APB access is active when pSel & pEnable. The block has zero wait states. Unmapped addresses read 0 and ignore writes.
- 0x00 DATA
  - Write pushes pWdata[7:0] into the TX FIFO.
  - Read returns {24'd0, RX head} and pops the RX FIFO.
  - A read with the RX FIFO empty returns 0 and does not pop.
- 0x04 CTRL (RW)
  - [0] TXEN, [1] RXEN, [3:2] DLS, [4] STOP, [5] PEN, [6] EPS.
  - [8] TXFLUSH and [9] RXFLUSH are write-1 pulses. They empty the FIFO and read back as 0.
- 0x08 BAUD (RW): [15:0] divisor.
- 0x0C STATUS (RO)
  - [0] TXEMPTY, [1] TXFULL, [2] RXEMPTY, [3] RXFULL.
  - [15:8] TX level, [23:16] RX level. Levels run 0..FIFO_DEPTH.
- 0x10 INT_EN (RW): bits 5:0 mask the matching INT_STAT bits.
- 0x14 INT_STAT
  - [0] RXTHR: level bit, RX level ≥ RX_THR. Read-only.
  - [1] TXTHR: level bit, TX level ≤ TX_THR. Read-only.
  - [2] RXOVR: sticky.
  - [3] FE: sticky.
  - [4] PE: sticky.
  - [5] TXOVF: sticky.
  - Writing 1 to a sticky bit clears it.
- 0x18 THR (RW): [7:0] RX_THR, [15:8] TX_THR.
- TX path
  - TxValid = TXEN & !TXEMPTY. TxData is the FIFO head.
  - On a cycle with TxValid & TxReady, the FIFO pops at that edge.
  - A DATA write while full is dropped and sets TXOVF. It is accepted if a TX pop occurs in the same cycle.
- RX path
  - RxValid while RXEN pushes RxData. RxValid while !RXEN is ignored, with no flags set.
  - A push while full is dropped and sets RXOVR. It is accepted if an APB pop occurs in the same cycle.
  - RxFrameErr sets FE and RxParityErr sets PE. The byte is still pushed.
- FIFOs: circular pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged.
- Flush wins over a same-cycle push or pop. A TX flush while TxValid & TxReady still discards the head.
- A sticky set event in the same cycle as a W1C of that bit leaves the bit set.
- Irq = registered |(INT_STAT[5:0] & INT_EN[5:0]).

## Timing
- Reset values
  - CTRL = 0, INT_EN = 0, INT_STAT sticky bits = 0.
  - BAUD = BAUD_RST, RX_THR = 1, TX_THR = 0.
  - FIFOs empty, TxValid = 0, Irq = 0.
  - All cfg outputs are 0 except BaudDiv = BAUD_RST.
- pReadData is combinational in the access phase and 0 outside a read access.
- Register writes commit at the access-phase edge and are visible to reads and outputs from the next cycle.
- FIFO status and levels update at the push/pop edge.
- The TX byte written at edge N gives TxValid = 1 after edge N (if TXEN).
- Sticky bits set at the event edge. Irq follows one edge later and drops one edge after a W1C clear or a mask change.
- Reset asserted mid-transfer empties both FIFOs immediately. No partial state survives.

## Test plan
- Reset → BAUD reads 0x0036, STATUS reads 0x00000005, Irq = 0, TxValid = 0.
- Set TXEN, TxReady = 0, write 0xA5, 0x3C → TX level 2 and TxData = 0xA5. Raise TxReady for 2 cycles → TxData 0x3C then TXEMPTY, TxValid = 0.
- Write 17 bytes with FIFO_DEPTH = 16 and TxReady = 0 → TX level 16, INT_STAT[5] = 1. Write 0x20 to INT_STAT → reads 0.
- Set RXEN, INT_EN = 0x01, RX_THR = 2, push 0x11 then 0x22 → Irq rises one cycle after the second push. Two DATA reads return 0x11, 0x22. Irq falls.
- Fill the RX FIFO, then pulse RxValid with RxFrameErr and an APB DATA read in the same cycle → byte accepted, level stays 16, FE = 1, RXOVR = 0.
- With the TX FIFO at level 3, write CTRL with TXFLUSH and a concurrent TxReady pop → TX level 0, TxValid = 0, and CTRL[8] reads 0.
